eic_input_filter: RTL and testbench
===================================

EIC_INPUT_FILTER -- requirements
Module: eic_input_filter

Interface
REQ-001 Parameter CHANNELS, default 32: number of interrupt input channels, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth, legal range 2..4.
REQ-003 Parameter FILTER_CYCLES, default 4: consecutive stable cycles required before the output changes, legal range 1..255.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RESETn  input  1  asynchronous, active-low reset.
REQ-006 signal_in  input  CHANNELS  raw asynchronous external interrupt lines.
REQ-007 filter_en  input  CHANNELS  per-channel filter enable, synchronous to CLK.
REQ-008 signal_out  output  CHANNELS  conditioned lines, registered; these drive the signal input of eic.
REQ-009 rise  output  CHANNELS  one-cycle pulse, registered, marking a 0->1 change of signal_out.
REQ-010 fall  output  CHANNELS  one-cycle pulse, registered, marking a 1->0 change of signal_out.

Function
REQ-011 Each channel passes signal_in through a SYNC_STAGES-deep flop chain; the last stage is the synchronized sample s.
REQ-012 Each channel holds a saturating counter cnt of width $clog2(FILTER_CYCLES+1).
REQ-013 When s equals signal_out, cnt clears to 0 on that edge.
REQ-014 When s differs from signal_out and cnt < FILTER_CYCLES-1, cnt increments by 1 on that edge.
REQ-015 When s differs from signal_out and cnt == FILTER_CYCLES-1, signal_out takes s and cnt clears to 0 on that edge.
REQ-016 Latency from a stable input change to signal_out is exactly SYNC_STAGES+FILTER_CYCLES edges; FILTER_CYCLES=1 gives pure synchronization.
REQ-017 A pulse of s shorter than FILTER_CYCLES cycles never reaches signal_out; a returning sample clears cnt per REQ-013, with no partial credit carried over.
REQ-018 With filter_en[i]=0, signal_out[i] takes s every edge and cnt[i] is held at 0; the synchronizer remains active.
REQ-019 A change of filter_en mid-count takes effect on the next edge; no spurious edge pulse results beyond the actual signal_out change.
REQ-020 rise[i] is high exactly in the cycle in which signal_out[i] first reads 1 after having been 0; fall[i] is the mirror; both are never high simultaneously.
REQ-021 Channels are fully independent; simultaneous changes on any set of channels are each handled per REQ-013..REQ-020.

Reset
REQ-022 RESETn low asynchronously clears all synchronizer stages, counters, signal_out, rise and fall to 0.
REQ-023 Deassertion of RESETn is assumed synchronized upstream; the first evaluation occurs on the first rising CLK edge with RESETn high.
REQ-024 Reset asserted mid-count discards the count; after release, a held-high input needs the full REQ-016 latency.

Configuration
REQ-025 Macro EIC_INPUT_FILTER_EN: when defined, counters and REQ-012..REQ-019 are compiled in.
REQ-026 When EIC_INPUT_FILTER_EN is undefined, no counters exist, filter_en is ignored, signal_out = s registered every edge (latency SYNC_STAGES), and rise/fall still operate.

Structure
REQ-027 The shared eic package holds the CHANNELS default, the SYNC_STAGES and FILTER_CYCLES defaults, and the counter-width function.
REQ-028 One sub-module, eic_filter_channel (synchronizer, counter and edge flops for one line), is instantiated CHANNELS times by a generate loop.

Verification
REQ-029 Defaults; signal_in[0] 0->1 held; filter_en=all 1 -> signal_out[0]=1 and rise[0]=1 exactly 6 edges after the change, and rise[0] low on the following cycle.
REQ-030 signal_in[5] high for 3 cycles then low; filter_en[5]=1 -> signal_out[5], rise[5] and fall[5] stay 0 throughout.
REQ-031 filter_en[12]=0; signal_in[12] high for 1 cycle -> signal_out[12]=1 for 1 cycle at edge 2; rise[12] then fall[12] pulse on consecutive cycles.
REQ-032 signal_in[0], [5] and [12] rise on the same edge; filter_en=all 1 -> all three outputs and rise bits assert on the same cycle (edge 6).
REQ-033 Input held high; RESETn pulsed low at count 2 -> outputs 0 immediately; after release, signal_out=1 exactly 6 edges later.
REQ-034 Build without EIC_INPUT_FILTER_EN; 1-cycle glitch on signal_in[3] -> signal_out[3] is 1 for 1 cycle at edge 2.

Source files
------------

// File: rtl/eic_input_filter_pkg.sv
// Shared definitions for the EIC input filter: parameter defaults and counter sizing.
// Filtering logic is compiled in only when EIC_INPUT_FILTER_EN is defined.
package eic_input_filter_pkg;

  localparam int EIC_CHANNELS_DEF      = 32;
  localparam int EIC_SYNC_STAGES_DEF   = 2;
  localparam int EIC_FILTER_CYCLES_DEF = 4;

  function automatic int cnt_width(input int filter_cycles);
    return (filter_cycles < 1) ? 1 : $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/eic_filter_channel.sv
// One interrupt line: synchronizer, optional stability filter (EIC_INPUT_FILTER_EN)
// and registered rise/fall edge pulses.
module eic_filter_channel
  import eic_input_filter_pkg::*;
#(
  parameter int SYNC_STAGES   = EIC_SYNC_STAGES_DEF,
  parameter int FILTER_CYCLES = EIC_FILTER_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic signal_in,
  input  logic filter_en,
  output logic signal_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_next_s;
  logic                   out_next_s;

  // The value the last sync stage takes on this edge; the unfiltered path loads it
  // directly so that signal_out equals the synchronized sample after every edge.
  assign s_next_s = sync_r[SYNC_STAGES-2];

  // synchronizer chain, stage 0 samples the raw line
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], signal_in};
    end
  end

`ifdef EIC_INPUT_FILTER_EN
  localparam int             CW       = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic          s_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;

  assign s_s = sync_r[SYNC_STAGES-1];

  // next output / counter: a sample must differ for FILTER_CYCLES edges to be accepted
  always_comb begin
    out_next_s = signal_out;
    cnt_next_s = '0;
    if (!filter_en) begin
      out_next_s = s_next_s;
      cnt_next_s = '0;
    end else if (s_s == signal_out) begin
      cnt_next_s = '0;
    end else if (cnt_r == CNT_LAST) begin
      out_next_s = s_s;
      cnt_next_s = '0;
    end else begin
      cnt_next_s = cnt_r + CW'(1);
    end
  end

  // stability counter
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end
`else
  localparam int unused_filter_cycles = FILTER_CYCLES;
  logic unused_s;

  assign unused_s = filter_en ^ sync_r[SYNC_STAGES-1];

  // without the filter the output simply follows the synchronized sample
  always_comb begin
    out_next_s = s_next_s;
  end
`endif

  // registered output and edge pulses derived from the output's next value
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      signal_out <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
    end else begin
      signal_out <= out_next_s;
      rise       <= out_next_s & ~signal_out;
      fall       <= ~out_next_s & signal_out;
    end
  end

endmodule

// File: rtl/eic_input_filter.sv
// EIC input conditioning: CHANNELS independent synchronize/filter/edge-detect lanes.
// Define EIC_INPUT_FILTER_EN to compile in the per-channel stability filter.
module eic_input_filter
  import eic_input_filter_pkg::*;
#(
  parameter int CHANNELS      = EIC_CHANNELS_DEF,
  parameter int SYNC_STAGES   = EIC_SYNC_STAGES_DEF,
  parameter int FILTER_CYCLES = EIC_FILTER_CYCLES_DEF
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic [CHANNELS-1:0] signal_in,
  input  logic [CHANNELS-1:0] filter_en,
  output logic [CHANNELS-1:0] signal_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    eic_filter_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_ch (
      .CLK       (CLK),
      .RESETn    (RESETn),
      .signal_in (signal_in[g]),
      .filter_en (filter_en[g]),
      .signal_out(signal_out[g]),
      .rise      (rise[g]),
      .fall      (fall[g])
    );
  end

endmodule

// File: tb/tb_eic_input_filter.sv
// Table-driven scoreboard bench for eic_input_filter; expectations follow the
// filtered behaviour when EIC_INPUT_FILTER_EN is defined, plain sync otherwise.
module tb_eic_input_filter;

  localparam logic [31:0] ALL = 32'hFFFF_FFFF;
  localparam logic [31:0] Z   = 32'h0000_0000;
  localparam logic [31:0] B0  = 32'h0000_0001;
  localparam logic [31:0] B1  = 32'h0000_0002;
  localparam logic [31:0] B3  = 32'h0000_0008;
  localparam logic [31:0] B5  = 32'h0000_0020;
  localparam logic [31:0] B7  = 32'h0000_0080;
  localparam logic [31:0] B12 = 32'h0000_1000;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic [31:0] signal_in;
  logic [31:0] filter_en;
  logic [31:0] signal_out;
  logic [31:0] rise;
  logic [31:0] fall;

  typedef struct {
    logic [31:0] sin;
    logic [31:0] en;
    logic [31:0] out;
    logic [31:0] ri;
    logic [31:0] fa;
  } vec_t;

  typedef struct {
    logic [31:0] out;
    logic [31:0] ri;
    logic [31:0] fa;
    string       nm;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  eic_input_filter dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .signal_in (signal_in),
    .filter_en (filter_en),
    .signal_out(signal_out),
    .rise      (rise),
    .fall      (fall)
  );

  always #5 CLK = ~CLK;

  task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                     input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.sin = a; v.en = b; v.out = c; v.ri = d; v.fa = e;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // apply one cycle of stimulus, queue its expectation, compare after the edge
  task automatic drive(input vec_t v, input string nm);
    exp_t e;
    signal_in = v.sin;
    filter_en = v.en;
    e.out = v.out; e.ri = v.ri; e.fa = v.fa; e.nm = nm;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    cmp({e.nm, ".out"},  signal_out,  e.out);
    cmp({e.nm, ".rise"}, rise,        e.ri);
    cmp({e.nm, ".fall"}, fall,        e.fa);
    cmp({e.nm, ".excl"}, rise & fall, Z);
  endtask

  initial begin
    vec_t        v;
    int          flat;
    logic [31:0] m;
    logic [31:0] p;
    logic [31:0] q;

    RESETn    = 1'b0;
    signal_in = Z;
    filter_en = ALL;
    #12;
    cmp("reset.out",  signal_out, Z);
    cmp("reset.rise", rise,       Z);
    cmp("reset.fall", fall,       Z);
    @(negedge CLK);
    RESETn = 1'b1;

`ifdef EIC_INPUT_FILTER_EN
    flat = 6;
    // ch0 rise and fall with full latency
    for (int k = 0; k < 5; k++) add(B0, ALL, Z, Z, Z);
    add(B0, ALL, B0, B0, Z);
    add(B0, ALL, B0, Z, Z);
    for (int k = 0; k < 5; k++) add(Z, ALL, B0, Z, Z);
    add(Z, ALL, Z, Z, B0);
    add(Z, ALL, Z, Z, Z);
    // ch5 3-cycle pulse is rejected
    for (int k = 0; k < 3; k++) add(B5, ALL, Z, Z, Z);
    for (int k = 0; k < 6; k++) add(Z, ALL, Z, Z, Z);
    // ch12 unfiltered 1-cycle glitch passes
    add(B12, ALL & ~B12, Z, Z, Z);
    add(Z, ALL & ~B12, B12, B12, Z);
    add(Z, ALL & ~B12, Z, Z, B12);
    add(Z, ALL & ~B12, Z, Z, Z);
    // three channels change together
    m = B0 | B5 | B12;
    for (int k = 0; k < 5; k++) add(m, ALL, Z, Z, Z);
    add(m, ALL, m, m, Z);
    add(m, ALL, m, Z, Z);
    for (int k = 0; k < 5; k++) add(Z, ALL, m, Z, Z);
    add(Z, ALL, Z, Z, m);
    add(Z, ALL, Z, Z, Z);
    // ch7 filter disabled mid-count, then re-enabled, then disabled on release
    add(B7, ALL, Z, Z, Z);
    add(B7, ALL, Z, Z, Z);
    add(B7, ALL, Z, Z, Z);
    add(B7, ALL & ~B7, B7, B7, Z);
    add(B7, ALL, B7, Z, Z);
    add(Z, ALL & ~B7, B7, Z, Z);
    add(Z, ALL & ~B7, Z, Z, B7);
    add(Z, ALL & ~B7, Z, Z, Z);
`else
    flat = 2;
    // ch3 1-cycle glitch passes, filter_en has no effect
    add(B3, ALL, Z, Z, Z);
    add(Z, ALL, B3, B3, Z);
    add(Z, ALL, Z, Z, B3);
    add(Z, ALL, Z, Z, Z);
    add(B3, Z, Z, Z, Z);
    add(Z, Z, B3, B3, Z);
    add(Z, Z, Z, Z, B3);
    add(Z, Z, Z, Z, Z);
    // every lane at once
    add(ALL, ALL, Z, Z, Z);
    add(ALL, ALL, ALL, ALL, Z);
    add(Z, ALL, ALL, Z, Z);
    add(Z, ALL, Z, Z, ALL);
    add(Z, ALL, Z, Z, Z);
    // mixed patterns with overlapping rise and fall
    p = 32'hA5A5_0F0F;
    q = 32'h5A5A_FF00;
    add(p, ALL, Z, Z, Z);
    add(p, ALL, p, p, Z);
    add(q, ALL, p, Z, Z);
    add(q, ALL, q, q & ~p, p & ~q);
    add(Z, ALL, q, Z, Z);
    add(Z, ALL, Z, Z, q);
    add(Z, ALL, Z, Z, Z);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i], $sformatf("vec%0d", i));
    end

    // reset mid-count: ch0 filtered (if built), ch1 unfiltered, input held high
    m = B0 | B1;
    for (int e = 1; e <= 4; e++) begin
      v.sin = m; v.en = ALL & ~B1;
      v.out = ((e >= 2) ? B1 : Z) | ((e >= flat) ? B0 : Z);
      v.ri  = ((e == 2) ? B1 : Z) | ((e == flat) ? B0 : Z);
      v.fa  = Z;
      drive(v, $sformatf("pre_rst%0d", e));
    end
    #2;
    RESETn = 1'b0;
    #1;
    cmp("rst_async.out",  signal_out, Z);
    cmp("rst_async.rise", rise,       Z);
    cmp("rst_async.fall", fall,       Z);
    @(negedge CLK);
    RESETn = 1'b1;
    for (int e = 1; e <= flat + 1; e++) begin
      v.sin = m; v.en = ALL & ~B1;
      v.out = ((e >= 2) ? B1 : Z) | ((e >= flat) ? B0 : Z);
      v.ri  = ((e == 2) ? B1 : Z) | ((e == flat) ? B0 : Z);
      v.fa  = Z;
      drive(v, $sformatf("post_rst%0d", e));
    end

    cmp("sb_empty", 32'(sb.size()), Z);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
